i2c_reg_slave: RTL and testbench
================================

I2C_REG_SLAVE -- requirements
Module: i2c_reg_slave

Interface
REQ-001 The block SHALL have parameter SLAVE_ADDR, default 7'h14, the 7-bit bus address it answers to.
REQ-002 The block SHALL have parameter NREG, default 8, the number of 8-bit registers (2..256).
REQ-003 The block SHALL have parameter FILT, default 3, the glitch-filter length in clk cycles (1..7).
REQ-004 Port clk  input  1  system clock; one clock domain; must be at least 8x SCL rate.
REQ-005 Port rst_n  input  1  asynchronous active-low reset.
REQ-006 Port scl_i  input  1  raw SCL pad input, asynchronous to clk.
REQ-007 Port sda_i  input  1  raw SDA pad input, asynchronous to clk.
REQ-008 Port sda_oe  output  1  1 = pull SDA low (open-drain), 0 = release.
REQ-009 Port wr_valid  output  1  one-clk pulse per register written by the bus master.
REQ-010 Port wr_idx  output  $clog2(NREG)  index of the register written; valid with wr_valid.
REQ-011 Port wr_data  output  8  byte written; valid with wr_valid.
REQ-012 Port regs_o  output  8*NREG  flat register contents, reg k at bits [8k+7:8k].
REQ-013 Port busy  output  1  high from an addressed START until STOP or NACK release.

Function
REQ-014 scl_i/sda_i SHALL pass a 2-flop synchroniser, then a FILT-cycle stable filter; all logic uses filtered levels and their edges only.
REQ-015 START: filtered SDA falls while SCL high; STOP: SDA rises while SCL high; both are detected in every state, including mid-byte.
REQ-016 States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, WAIT_STOP.
REQ-017 START from any state SHALL clear the bit counter and enter ADDR (repeated START supported); STOP from any state enters IDLE.
REQ-018 Bits are sampled on filtered SCL rising edge, MSB first; 8 bits per byte.
REQ-019 ADDR: on address match the block enters ADDR_ACK and drives ACK; on mismatch it leaves sda_oe=0 and enters WAIT_STOP.
REQ-020 After ADDR_ACK: R/W=0 -> PTR; R/W=1 -> RD.
REQ-021 PTR: the received byte, taken modulo NREG, loads the pointer, then the block ACKs (PTR_ACK) and enters WR.
REQ-022 WR: each received byte is ACKed, written to reg[ptr], pulses wr_valid with wr_idx=ptr, then ptr = (ptr+1) mod NREG.
REQ-023 RD: reg[ptr] is shifted out; in RD_ACK master ACK -> ptr+1 mod NREG, next byte; master NACK -> release SDA, WAIT_STOP.
REQ-024 sda_oe SHALL change only 1 clk after a filtered SCL falling edge, never while SCL high, except release on START/STOP.
REQ-025 wr_valid SHALL assert exactly one clk, on the SCL rising edge sampling the 8th data bit.
REQ-026 A byte that is still incomplete when START/STOP arrives SHALL be discarded, with no write and no pointer change.
REQ-027 busy SHALL be high from ADDR_ACK entry until IDLE or WAIT_STOP.

Reset
REQ-028 rst_n low SHALL asynchronously force: state IDLE, sda_oe 0, wr_valid 0, wr_idx 0, wr_data 0, busy 0, pointer 0, all regs 0, filters to 1 (bus idle).
REQ-029 Reset asserted mid-transfer SHALL release SDA at once; after release, the block ignores the bus until the next START.

Structure
REQ-030 Package i2c_pkg SHALL hold the state enum, the START/STOP event type and the default SLAVE_ADDR constant.
REQ-031 Sub-module i2c_line_filter SHALL hold the synchroniser, filter and edge/START/STOP detection; it is instantiated once for the SCL/SDA pair.

Verification
REQ-032 Write 0x28, 0x03, 0xA5, 0x5A, STOP -> two ACKs plus data ACKs; wr_valid pulses with (3,A5) and (4,5A); regs_o shows reg3=A5, reg4=5A.
REQ-033 Write 0x28, 0x07, 0x11, 0x22 (NREG=8) -> reg7=11, reg0=22 (wrap).
REQ-034 Write 0x28, 0x03, Sr, 0x29, then read 2 bytes with ACK then NACK -> A5, 5A returned; SDA released after NACK.
REQ-035 Address 0x2A -> no ACK, sda_oe stays 0, busy stays 0, regs unchanged until STOP.
REQ-036 2-clk SCL glitch during a data bit with FILT=3 -> no extra bit sampled; byte intact.
REQ-037 rst_n low after the 4th data bit of a write -> sda_oe 0 immediately, regs 0, no wr_valid; the next full transaction succeeds.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register slave.
package i2c_pkg;

   localparam logic [6:0] DefSlaveAddr = 7'h14;

   typedef enum logic [3:0] {
      StIdle,
      StAddr,
      StAddrAck,
      StPtr,
      StPtrAck,
      StWr,
      StWrAck,
      StRd,
      StRdAck,
      StWaitStop
   } state_e;

   typedef enum logic [1:0] {
      EvNone,
      EvStart,
      EvStop
   } bus_ev_e;

endpackage

// File: rtl/i2c_line_filter.sv
// Synchronises and glitch-filters SCL/SDA, then derives SCL edges and START/STOP events.
module i2c_line_filter
   import i2c_pkg::*;
#(
   parameter int unsigned FILT = 3
) (
   input  logic    clk,
   input  logic    rst_n,
   input  logic    scl_i,
   input  logic    sda_i,
   output logic    sda,
   output logic    scl_rise,
   output logic    scl_fall,
   output bus_ev_e ev
);

   logic [1:0] scl_sync, sda_sync;
   logic [2:0] scl_cnt, sda_cnt;
   logic       scl_f, sda_f, scl_p, sda_p;

   // A level is accepted only after FILT consecutive samples disagree with the current one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync <= 2'b11;
         sda_sync <= 2'b11;
         scl_cnt  <= '0;
         sda_cnt  <= '0;
         scl_f    <= 1'b1;
         sda_f    <= 1'b1;
         scl_p    <= 1'b1;
         sda_p    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[0], scl_i};
         sda_sync <= {sda_sync[0], sda_i};
         if (scl_sync[1] == scl_f) begin
            scl_cnt <= '0;
         end else if (scl_cnt == 3'(FILT - 1)) begin
            scl_f   <= scl_sync[1];
            scl_cnt <= '0;
         end else begin
            scl_cnt <= scl_cnt + 3'd1;
         end
         if (sda_sync[1] == sda_f) begin
            sda_cnt <= '0;
         end else if (sda_cnt == 3'(FILT - 1)) begin
            sda_f   <= sda_sync[1];
            sda_cnt <= '0;
         end else begin
            sda_cnt <= sda_cnt + 3'd1;
         end
         scl_p <= scl_f;
         sda_p <= sda_f;
      end
   end

   assign sda      = sda_f;
   assign scl_rise = scl_f & ~scl_p;
   assign scl_fall = ~scl_f & scl_p;

   always_comb begin
      ev = EvNone;
      if (scl_f && scl_p) begin
         if (sda_p && !sda_f) ev = EvStart;
         else if (!sda_p && sda_f) ev = EvStop;
      end
   end

endmodule

// File: rtl/i2c_reg_slave.sv
// I2C slave exposing NREG byte registers with an auto-incrementing pointer.
module i2c_reg_slave
   import i2c_pkg::*;
#(
   parameter logic [6:0]  SLAVE_ADDR = DefSlaveAddr,
   parameter int unsigned NREG       = 8,
   parameter int unsigned FILT       = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    scl_i,
   input  logic                    sda_i,
   output logic                    sda_oe,
   output logic                    wr_valid,
   output logic [$clog2(NREG)-1:0] wr_idx,
   output logic [7:0]              wr_data,
   output logic [8*NREG-1:0]       regs_o,
   output logic                    busy
);

   localparam int unsigned PW = $clog2(NREG);

   logic          sda, scl_rise, scl_fall;
   bus_ev_e       ev;
   state_e        state;
   logic [3:0]    cnt;
   logic [6:0]    sh;
   logic          rw, mack;
   logic [PW-1:0] ptr, ptr_nxt, ptr_mod;
   logic [7:0]    regs [NREG];
   logic [7:0]    rx_byte;

   i2c_line_filter #(
      .FILT(FILT)
   ) u_filter (
      .clk     (clk),
      .rst_n   (rst_n),
      .scl_i   (scl_i),
      .sda_i   (sda_i),
      .sda     (sda),
      .scl_rise(scl_rise),
      .scl_fall(scl_fall),
      .ev      (ev)
   );

   assign rx_byte = {sh, sda};
   assign ptr_nxt = (ptr == PW'(NREG - 1)) ? '0 : ptr + 1'b1;
   assign ptr_mod = PW'(32'(rx_byte) % NREG);

   for (genvar k = 0; k < NREG; k++) begin : g_regs
      assign regs_o[8*k +: 8] = regs[k];
   end

   // ACK states: first SCL fall drives ACK, second SCL fall releases and moves on.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= StIdle;
         sda_oe   <= 1'b0;
         wr_valid <= 1'b0;
         wr_idx   <= '0;
         wr_data  <= '0;
         busy     <= 1'b0;
         ptr      <= '0;
         cnt      <= '0;
         sh       <= '0;
         rw       <= 1'b0;
         mack     <= 1'b0;
         for (int k = 0; k < NREG; k++) regs[k] <= '0;
      end else begin
         wr_valid <= 1'b0;
         if (ev == EvStart) begin
            state  <= StAddr;
            cnt    <= '0;
            sda_oe <= 1'b0;
            mack   <= 1'b0;
         end else if (ev == EvStop) begin
            state  <= StIdle;
            cnt    <= '0;
            sda_oe <= 1'b0;
            busy   <= 1'b0;
            mack   <= 1'b0;
         end else begin
            case (state)
               StAddr, StPtr, StWr: begin
                  if (scl_rise) begin
                     sh  <= rx_byte[6:0];
                     cnt <= cnt + 4'd1;
                     if (cnt == 4'd7) begin
                        cnt <= '0;
                        if (state == StAddr) begin
                           if (rx_byte[7:1] == SLAVE_ADDR) begin
                              rw    <= rx_byte[0];
                              busy  <= 1'b1;
                              state <= StAddrAck;
                           end else begin
                              busy  <= 1'b0;
                              state <= StWaitStop;
                           end
                        end else if (state == StPtr) begin
                           ptr   <= ptr_mod;
                           state <= StPtrAck;
                        end else begin
                           regs[ptr] <= rx_byte;
                           wr_valid  <= 1'b1;
                           wr_idx    <= ptr;
                           wr_data   <= rx_byte;
                           ptr       <= ptr_nxt;
                           state     <= StWrAck;
                        end
                     end
                  end
               end
               StAddrAck, StPtrAck, StWrAck: begin
                  if (scl_fall) begin
                     cnt <= '0;
                     if (!sda_oe) begin
                        sda_oe <= 1'b1;
                     end else if (state == StAddrAck && rw) begin
                        sh     <= regs[ptr][6:0];
                        sda_oe <= ~regs[ptr][7];
                        state  <= StRd;
                     end else begin
                        sda_oe <= 1'b0;
                        state  <= (state == StAddrAck) ? StPtr : StWr;
                     end
                  end
               end
               StRd: begin
                  if (scl_rise) begin
                     cnt <= cnt + 4'd1;
                  end else if (scl_fall) begin
                     if (cnt == 4'd8) begin
                        sda_oe <= 1'b0;
                        cnt    <= '0;
                        state  <= StRdAck;
                     end else begin
                        sda_oe <= ~sh[6];
                        sh     <= {sh[5:0], 1'b0};
                     end
                  end
               end
               StRdAck: begin
                  if (scl_rise) begin
                     if (sda) begin
                        busy  <= 1'b0;
                        state <= StWaitStop;
                     end else begin
                        mack <= 1'b1;
                        ptr  <= ptr_nxt;
                     end
                  end else if (scl_fall && mack) begin
                     mack   <= 1'b0;
                     sh     <= regs[ptr][6:0];
                     sda_oe <= ~regs[ptr][7];
                     cnt    <= '0;
                     state  <= StRd;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Directed bench: bit-banged I2C master against i2c_reg_slave with hand-computed expectations.
module tb_i2c_reg_slave;

   localparam int Q = 10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        m_scl = 1'b1;
   logic        m_sda = 1'b1;
   logic        sda_bus;
   logic        sda_oe, wr_valid, busy;
   logic [2:0]  wr_idx;
   logic [7:0]  wr_data;
   logic [63:0] regs_o;

   int total = 0;
   int bad = 0;

   logic [10:0] wlog [64];
   int          wn = 0;
   int          oe_cnt = 0;
   int          busy_cnt = 0;

   assign sda_bus = m_sda & ~sda_oe;

   always #5 clk = ~clk;

   i2c_reg_slave #(
      .SLAVE_ADDR(7'h14),
      .NREG      (8),
      .FILT      (3)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .scl_i   (m_scl),
      .sda_i   (sda_bus),
      .sda_oe  (sda_oe),
      .wr_valid(wr_valid),
      .wr_idx  (wr_idx),
      .wr_data (wr_data),
      .regs_o  (regs_o),
      .busy    (busy)
   );

   always @(negedge clk) begin
      if (wr_valid) begin
         wlog[wn[5:0]] <= {wr_idx, wr_data};
         wn <= wn + 1;
      end
      if (sda_oe) oe_cnt <= oe_cnt + 1;
      if (busy) busy_cnt <= busy_cnt + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clock_bit(input logic b, input logic g, output logic s);
      m_sda = b;
      wait_clk(Q);
      m_scl = 1'b1;
      if (g) begin
         wait_clk(3);
         m_scl = 1'b0;
         wait_clk(2);
         m_scl = 1'b1;
         wait_clk(Q - 5);
      end else begin
         wait_clk(Q);
      end
      s = sda_bus;
      wait_clk(Q);
      m_scl = 1'b0;
      wait_clk(Q);
   endtask

   task automatic i2c_start();
      m_sda = 1'b1;
      wait_clk(Q);
      m_scl = 1'b1;
      wait_clk(Q);
      m_sda = 1'b0;
      wait_clk(Q);
      m_scl = 1'b0;
      wait_clk(Q);
   endtask

   task automatic i2c_stop();
      m_sda = 1'b0;
      wait_clk(Q);
      m_scl = 1'b1;
      wait_clk(Q);
      m_sda = 1'b1;
      wait_clk(Q);
   endtask

   // glitch_bit selects which bit (7..0) gets a short SCL low pulse; -1 for none.
   task automatic write_byte(input logic [7:0] d, input int glitch_bit, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) clock_bit(d[i], (i == glitch_bit), s);
      clock_bit(1'b1, 1'b0, s);
      ack = ~s;
   endtask

   task automatic read_byte(input logic master_ack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         clock_bit(1'b1, 1'b0, s);
         d[i] = s;
      end
      clock_bit(~master_ack, 1'b0, s);
   endtask

   initial begin
      logic       ack;
      logic       s;
      logic [7:0] rd;
      int         w0, oe0, busy0;

      // Reset state
      wait_clk(5);
      chk("rst_sda_oe", 64'(sda_oe), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_wr_valid", 64'(wr_valid), 64'd0);
      chk("rst_wr_idx_data", 64'({wr_idx, wr_data}), 64'd0);
      chk("rst_regs", regs_o, 64'd0);
      rst_n = 1'b1;
      wait_clk(10);

      // Write 0x03 <- A5, 5A
      w0 = wn;
      i2c_start();
      write_byte(8'h28, -1, ack);
      chk("wr_addr_ack", 64'(ack), 64'd1);
      chk("wr_busy", 64'(busy), 64'd1);
      write_byte(8'h03, -1, ack);
      chk("wr_ptr_ack", 64'(ack), 64'd1);
      write_byte(8'hA5, -1, ack);
      chk("wr_d0_ack", 64'(ack), 64'd1);
      write_byte(8'h5A, -1, ack);
      chk("wr_d1_ack", 64'(ack), 64'd1);
      i2c_stop();
      wait_clk(10);
      chk("wr_pulses", 64'(wn - w0), 64'd2);
      chk("wr_log0", 64'(wlog[w0]), 64'({3'd3, 8'hA5}));
      chk("wr_log1", 64'(wlog[w0 + 1]), 64'({3'd4, 8'h5A}));
      chk("wr_regs", regs_o, 64'h0000_005A_A500_0000);
      chk("wr_busy_after_stop", 64'(busy), 64'd0);

      // Pointer wrap 7 -> 0
      w0 = wn;
      i2c_start();
      write_byte(8'h28, -1, ack);
      write_byte(8'h07, -1, ack);
      write_byte(8'h11, -1, ack);
      write_byte(8'h22, -1, ack);
      chk("wrap_ack", 64'(ack), 64'd1);
      i2c_stop();
      wait_clk(10);
      chk("wrap_log0", 64'(wlog[w0]), 64'({3'd7, 8'h11}));
      chk("wrap_log1", 64'(wlog[w0 + 1]), 64'({3'd0, 8'h22}));
      chk("wrap_regs", regs_o, 64'h1100_005A_A500_0022);

      // Set pointer, repeated START, read two bytes
      w0 = wn;
      i2c_start();
      write_byte(8'h28, -1, ack);
      write_byte(8'h03, -1, ack);
      i2c_start();
      write_byte(8'h29, -1, ack);
      chk("rd_addr_ack", 64'(ack), 64'd1);
      read_byte(1'b1, rd);
      chk("rd_byte0", 64'(rd), 64'hA5);
      read_byte(1'b0, rd);
      chk("rd_byte1", 64'(rd), 64'h5A);
      chk("rd_release", 64'(sda_oe), 64'd0);
      chk("rd_busy_nack", 64'(busy), 64'd0);
      i2c_stop();
      wait_clk(10);
      chk("rd_no_writes", 64'(wn - w0), 64'd0);

      // Wrong address ignored
      w0 = wn;
      oe0 = oe_cnt;
      busy0 = busy_cnt;
      i2c_start();
      write_byte(8'h2A, -1, ack);
      chk("bad_addr_nack", 64'(ack), 64'd0);
      write_byte(8'h03, -1, ack);
      write_byte(8'h77, -1, ack);
      chk("bad_data_nack", 64'(ack), 64'd0);
      i2c_stop();
      wait_clk(10);
      chk("bad_oe_never", 64'(oe_cnt - oe0), 64'd0);
      chk("bad_busy_never", 64'(busy_cnt - busy0), 64'd0);
      chk("bad_no_writes", 64'(wn - w0), 64'd0);
      chk("bad_regs", regs_o, 64'h1100_005A_A500_0022);

      // 2-clk SCL glitch during a data bit
      w0 = wn;
      i2c_start();
      write_byte(8'h28, -1, ack);
      write_byte(8'h05, -1, ack);
      write_byte(8'h3C, 4, ack);
      chk("glitch_ack", 64'(ack), 64'd1);
      i2c_stop();
      wait_clk(10);
      chk("glitch_pulses", 64'(wn - w0), 64'd1);
      chk("glitch_log", 64'(wlog[w0]), 64'({3'd5, 8'h3C}));
      chk("glitch_regs", regs_o, 64'h1100_3C5A_A500_0022);

      // Reset mid-byte, then a clean transaction
      w0 = wn;
      i2c_start();
      write_byte(8'h28, -1, ack);
      write_byte(8'h02, -1, ack);
      for (int i = 7; i >= 4; i--) clock_bit(1'(8'hC3 >> i), 1'b0, s);
      chk("mid_busy", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_oe", 64'(sda_oe), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_regs", regs_o, 64'd0);
      wait_clk(4);
      rst_n = 1'b1;
      wait_clk(10);
      for (int i = 3; i >= 0; i--) clock_bit(1'(8'hC3 >> i), 1'b0, s);
      clock_bit(1'b1, 1'b0, s);
      chk("mid_ignored_nack", 64'(s), 64'd1);
      i2c_stop();
      wait_clk(10);
      chk("mid_no_writes", 64'(wn - w0), 64'd0);
      i2c_start();
      write_byte(8'h28, -1, ack);
      write_byte(8'h01, -1, ack);
      write_byte(8'h99, -1, ack);
      chk("post_rst_ack", 64'(ack), 64'd1);
      i2c_stop();
      wait_clk(10);
      chk("post_rst_log", 64'(wlog[w0]), 64'({3'd1, 8'h99}));
      chk("post_rst_regs", regs_o, 64'h0000_0000_0000_9900);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
